// File: rtl/tap_ir_decoder_if.sv
// Strobe/data bundle between the TAP controller and the IR decoder.
// The controller side owns the strobes; the decoder side owns the decoded selects.
interface tap_ir_decoder_if #(
    parameter int IR_WIDTH = 4,
    parameter int NUM_USER = 2
);
    localparam int DRSEL_W = $clog2(NUM_USER + 3);
    localparam int USER_W  = (NUM_USER > 0) ? NUM_USER : 1;

    logic                captureIR_i;
    logic                shiftIR_i;
    logic                updateIR_i;
    logic                tdi_i;
    logic                irTdo_o;
    logic [IR_WIDTH-1:0] instruction_o;
    logic [DRSEL_W-1:0]  drSel_o;
    logic                bypassEnable_o;
    logic                scanEnable_o;
    logic                extest_mode_o;
    logic                sample_mode_o;
    logic                preload_mode_o;
    logic [USER_W-1:0]   userSel_o;
    logic                instrUnknown_o;

    modport master (
        output captureIR_i, shiftIR_i, updateIR_i, tdi_i,
        input  irTdo_o, instruction_o, drSel_o, bypassEnable_o, scanEnable_o,
               extest_mode_o, sample_mode_o, preload_mode_o, userSel_o, instrUnknown_o
    );

    modport slave (
        input  captureIR_i, shiftIR_i, updateIR_i, tdi_i,
        output irTdo_o, instruction_o, drSel_o, bypassEnable_o, scanEnable_o,
               extest_mode_o, sample_mode_o, preload_mode_o, userSel_o, instrUnknown_o
    );
endinterface

// File: rtl/tap_ir_decoder.sv
// JTAG instruction register (capture/shift/update) with a registered opcode decoder
// producing DR select, boundary-scan mode flags, user DR selects and an unknown flag.
module tap_ir_decoder #(
    parameter int                  IR_WIDTH     = 4,
    parameter logic [IR_WIDTH-1:0] EXTEST_OP    = 'h0,
    parameter logic [IR_WIDTH-1:0] SAMPLE_OP    = 'h1,
    parameter logic [IR_WIDTH-1:0] PRELOAD_OP   = 'h2,
    parameter logic [IR_WIDTH-1:0] IDCODE_OP    = 'h3,
    parameter logic [IR_WIDTH-1:0] USER_BASE_OP = 'h8,
    parameter int                  NUM_USER     = 2,
    parameter bit                  HAS_IDCODE   = 1'b1,
    parameter int                  DRSEL_W      = $clog2(NUM_USER + 3)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              testLogicReset_i,
    tap_ir_decoder_if.slave   bus
);
    localparam int USER_W = (NUM_USER > 0) ? NUM_USER : 1;
    localparam logic [IR_WIDTH-1:0] CAPTURE_PAT = {{(IR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [IR_WIDTH-1:0] RESET_OP    = HAS_IDCODE ? IDCODE_OP : {IR_WIDTH{1'b1}};

    typedef struct packed {
        logic [DRSEL_W-1:0] drsel;
        logic               byp;
        logic               scan;
        logic               ext;
        logic               smp;
        logic               pre;
        logic [USER_W-1:0]  usel;
        logic               unk;
    } dec_t;

    // Fixed opcodes are tested first so they win over any overlapping user opcode.
    function automatic dec_t decode(input logic [IR_WIDTH-1:0] op);
        dec_t d;
        d = '0;
        if (op == EXTEST_OP) begin
            d.scan  = 1'b1;
            d.ext   = 1'b1;
            d.drsel = DRSEL_W'(1);
        end else if (op == SAMPLE_OP) begin
            d.scan  = 1'b1;
            d.smp   = 1'b1;
            d.drsel = DRSEL_W'(1);
        end else if (op == PRELOAD_OP) begin
            d.scan  = 1'b1;
            d.pre   = 1'b1;
            d.drsel = DRSEL_W'(1);
        end else if (HAS_IDCODE && (op == IDCODE_OP)) begin
            d.drsel = DRSEL_W'(2);
        end else begin
            d.byp = 1'b1;
            d.unk = (op != {IR_WIDTH{1'b1}});
            for (int k = 0; k < NUM_USER; k++) begin
                if (d.byp && (op == USER_BASE_OP + IR_WIDTH'(k))) begin
                    d.byp     = 1'b0;
                    d.unk     = 1'b0;
                    d.usel[k] = 1'b1;
                    d.drsel   = DRSEL_W'(3 + k);
                end
            end
        end
        return d;
    endfunction

    logic [IR_WIDTH-1:0] sr_q, sr_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    dec_t                dec_q, dec_d;

    always_comb begin
        sr_d = sr_q;
        ir_d = ir_q;
        if (bus.updateIR_i) begin
            ir_d = sr_q;
        end else if (bus.shiftIR_i) begin
            sr_d = {bus.tdi_i, sr_q[IR_WIDTH-1:1]};
        end else if (bus.captureIR_i) begin
            sr_d = CAPTURE_PAT;
        end
        dec_d = decode(ir_d);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || testLogicReset_i) begin
            sr_q  <= CAPTURE_PAT;
            ir_q  <= RESET_OP;
            dec_q <= decode(RESET_OP);
        end else begin
            sr_q  <= sr_d;
            ir_q  <= ir_d;
            dec_q <= dec_d;
        end
    end

    assign bus.irTdo_o        = sr_q[0];
    assign bus.instruction_o  = ir_q;
    assign bus.drSel_o        = dec_q.drsel;
    assign bus.bypassEnable_o = dec_q.byp;
    assign bus.scanEnable_o   = dec_q.scan;
    assign bus.extest_mode_o  = dec_q.ext;
    assign bus.sample_mode_o  = dec_q.smp;
    assign bus.preload_mode_o = dec_q.pre;
    assign bus.userSel_o      = dec_q.usel;
    assign bus.instrUnknown_o = dec_q.unk;
endmodule

// File: tb/tb_tap_ir_decoder.sv
// Bench for tap_ir_decoder: three builds (default, no-IDCODE, 6-bit/4-user) share one
// strobe stream and are compared every cycle against an opcode-table model.
module tb_tap_ir_decoder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, tlr = 1'b0, cap = 1'b0, sh = 1'b0, upd = 1'b0, tdi = 1'b0;
    int   total = 0, bad = 0;
    bit   chk_en = 1'b0;

    tap_ir_decoder_if #(.IR_WIDTH(4), .NUM_USER(2)) if0();
    tap_ir_decoder_if #(.IR_WIDTH(4), .NUM_USER(2)) if1();
    tap_ir_decoder_if #(.IR_WIDTH(6), .NUM_USER(4)) if2();

    tap_ir_decoder u0 (.clk_i(clk), .rst_i(rst), .testLogicReset_i(tlr), .bus(if0));
    tap_ir_decoder #(.HAS_IDCODE(1'b0)) u1 (.clk_i(clk), .rst_i(rst), .testLogicReset_i(tlr), .bus(if1));
    tap_ir_decoder #(.IR_WIDTH(6), .NUM_USER(4)) u2 (.clk_i(clk), .rst_i(rst), .testLogicReset_i(tlr), .bus(if2));

    assign if0.captureIR_i = cap;  assign if0.shiftIR_i = sh;  assign if0.updateIR_i = upd;  assign if0.tdi_i = tdi;
    assign if1.captureIR_i = cap;  assign if1.shiftIR_i = sh;  assign if1.updateIR_i = upd;  assign if1.tdi_i = tdi;
    assign if2.captureIR_i = cap;  assign if2.shiftIR_i = sh;  assign if2.updateIR_i = upd;  assign if2.tdi_i = tdi;

    // flag bit positions: {tdo, bypass, scan, extest, sample, preload, unknown}
    localparam int F_TDO = 6, F_BYP = 5, F_SCAN = 4, F_EXT = 3, F_SMP = 2, F_PRE = 1, F_UNK = 0;

    int         a_instr[3], a_drsel[3], a_usel[3];
    logic [6:0] a_flg[3];

    always_comb begin
        a_instr[0] = int'(if0.instruction_o);
        a_drsel[0] = int'(if0.drSel_o);
        a_usel[0]  = int'(if0.userSel_o);
        a_flg[0]   = {if0.irTdo_o, if0.bypassEnable_o, if0.scanEnable_o, if0.extest_mode_o,
                      if0.sample_mode_o, if0.preload_mode_o, if0.instrUnknown_o};
        a_instr[1] = int'(if1.instruction_o);
        a_drsel[1] = int'(if1.drSel_o);
        a_usel[1]  = int'(if1.userSel_o);
        a_flg[1]   = {if1.irTdo_o, if1.bypassEnable_o, if1.scanEnable_o, if1.extest_mode_o,
                      if1.sample_mode_o, if1.preload_mode_o, if1.instrUnknown_o};
        a_instr[2] = int'(if2.instruction_o);
        a_drsel[2] = int'(if2.drSel_o);
        a_usel[2]  = int'(if2.userSel_o);
        a_flg[2]   = {if2.irTdo_o, if2.bypassEnable_o, if2.scanEnable_o, if2.extest_mode_o,
                      if2.sample_mode_o, if2.preload_mode_o, if2.instrUnknown_o};
    end

    // ---------------- reference model ----------------
    int LW[3]  = '{4, 4, 6};
    bit LID[3] = '{1'b1, 1'b0, 1'b1};
    int LNU[3] = '{2, 2, 4};
    int m_sr[3], m_ir[3];

    typedef struct {
        int drsel;
        int usel;
        bit byp, scan, ext, smp, pre, unk;
    } exp_t;

    // Opcode table: 0 EXTEST, 1 SAMPLE, 2 PRELOAD, 3 IDCODE, 8+k USER k, all-ones BYPASS.
    function automatic exp_t model_dec(input int op, input int w, input bit hid, input int nu);
        exp_t e;
        int   mask;
        int   k;
        mask = (1 << w) - 1;
        k = (op - 8) & mask;
        e.drsel = 0; e.usel = 0;
        e.byp = 0; e.scan = 0; e.ext = 0; e.smp = 0; e.pre = 0; e.unk = 0;
        if (op == 0) begin
            e.scan = 1; e.ext = 1; e.drsel = 1;
        end else if (op == 1) begin
            e.scan = 1; e.smp = 1; e.drsel = 1;
        end else if (op == 2) begin
            e.scan = 1; e.pre = 1; e.drsel = 1;
        end else if (op == 3 && hid) begin
            e.drsel = 2;
        end else if (k < nu) begin
            e.drsel = 3 + k; e.usel = 1 << k;
        end else begin
            e.byp = 1; e.unk = (op != mask);
        end
        return e;
    endfunction

    always @(posedge clk) begin
        for (int l = 0; l < 3; l++) begin
            int mask;
            mask = (1 << LW[l]) - 1;
            if (rst || tlr) begin
                m_sr[l] = 1;
                m_ir[l] = LID[l] ? 3 : mask;
            end else if (upd) begin
                m_ir[l] = m_sr[l];
            end else if (sh) begin
                m_sr[l] = (m_sr[l] >> 1) | (int'(tdi) << (LW[l] - 1));
            end else if (cap) begin
                m_sr[l] = 1;
            end
        end
    end

    function automatic void chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s @%0t: actual=%0d required=%0d", name, $time, act, req);
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int l = 0; l < 3; l++) begin
                exp_t e;
                int   ef;
                e  = model_dec(m_ir[l], LW[l], LID[l], LNU[l]);
                ef = ((m_sr[l] & 1) << F_TDO) | (int'(e.byp) << F_BYP) | (int'(e.scan) << F_SCAN)
                   | (int'(e.ext) << F_EXT) | (int'(e.smp) << F_SMP) | (int'(e.pre) << F_PRE)
                   | (int'(e.unk) << F_UNK);
                chk($sformatf("lane%0d instruction", l), a_instr[l], m_ir[l]);
                chk($sformatf("lane%0d drSel", l), a_drsel[l], e.drsel);
                chk($sformatf("lane%0d userSel", l), a_usel[l], e.usel);
                chk($sformatf("lane%0d flags", l), int'(a_flg[l]), ef);
            end
            begin
                int n;
                n = int'(a_flg[2][F_BYP]) + int'(a_flg[2][F_SCAN]) + int'(a_drsel[2] == 2)
                  + $countones(a_usel[2]);
                chk("lane2 one-hot select", n, 1);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit r, input bit t, input bit c, input bit s, input bit u, input bit d);
        rst = r; tlr = t; cap = c; sh = s; upd = u; tdi = d;
        @(negedge clk);
    endtask

    task automatic shift_in(input int v, input int w);
        for (int i = 0; i < w; i++) cyc(0, 0, 0, 1, 0, bit'((v >> i) & 1));
    endtask

    initial begin
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk_en = 1'b1;

        chk("reset instruction", a_instr[0], 3);
        chk("reset drSel", a_drsel[0], 2);
        chk("reset bypass", int'(a_flg[0][F_BYP]), 0);
        chk("reset modes", int'(a_flg[0][F_SCAN:F_UNK]), 0);
        chk("noid reset instruction", a_instr[1], 15);
        chk("noid reset drSel", a_drsel[1], 0);
        chk("noid reset bypass", int'(a_flg[1][F_BYP]), 1);

        cyc(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("capture tdo bit%0d", i), int'(a_flg[0][F_TDO]), (i == 0) ? 1 : 0);
            cyc(0, 0, 0, 1, 0, 0);
        end
        cyc(0, 0, 0, 0, 1, 0);
        chk("extest mode", int'(a_flg[0][F_EXT]), 1);
        chk("extest scan", int'(a_flg[0][F_SCAN]), 1);
        chk("extest drSel", a_drsel[0], 1);

        shift_in(9, 4);
        cyc(0, 0, 0, 0, 1, 0);
        chk("user1 userSel", a_usel[0], 2);
        chk("user1 drSel", a_drsel[0], 4);
        chk("user1 unknown", int'(a_flg[0][F_UNK]), 0);

        shift_in('hC, 4);
        cyc(0, 0, 0, 0, 1, 0);
        chk("op C bypass", int'(a_flg[0][F_BYP]), 1);
        chk("op C drSel", a_drsel[0], 0);
        chk("op C unknown", int'(a_flg[0][F_UNK]), 1);

        shift_in(1, 4);
        chk("shift no update drSel", a_drsel[0], 0);
        chk("shift no update unknown", int'(a_flg[0][F_UNK]), 1);
        cyc(0, 0, 0, 1, 1, 1);
        chk("update over shift instruction", a_instr[0], 1);
        chk("update over shift sample", int'(a_flg[0][F_SMP]), 1);
        cyc(0, 0, 0, 0, 1, 0);
        chk("sr not shifted instruction", a_instr[0], 1);

        shift_in(3, 2);
        cyc(0, 1, 0, 0, 0, 0);
        chk("tlr instruction", a_instr[0], 3);
        chk("tlr tdo", int'(a_flg[0][F_TDO]), 1);
        cyc(0, 0, 0, 0, 1, 0);
        chk("post-tlr update instruction", a_instr[0], 1);
        chk("post-tlr update sample", int'(a_flg[0][F_SMP]), 1);

        for (int op = 0; op < 64; op++) begin
            shift_in(op, 6);
            cyc(0, 0, 0, 0, 1, 0);
        end

        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom % 64) == 0, ($urandom % 64) == 0, ($urandom % 8) == 0,
                ($urandom % 2) == 0, ($urandom % 8) == 0, 1'($urandom));
        end
        cyc(0, 0, 0, 0, 0, 0);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
